// File: rtl/tdm_demux10_if.sv
// Bundle of the serial input stream and the demultiplexed outputs of tdm_demux10.
// The master drives the stream and the slave is the demultiplexer.
interface tdm_demux10_if;
  logic       IN;
  logic       VALID;
  logic       SYNC;
  logic       MODE;
  logic [3:0] S;
  logic [9:0] OUT;
  logic [3:0] SLOT;
  logic       FRAME_DONE;
  logic       ERR;

  modport master (
    output IN, VALID, SYNC, MODE, S,
    input  OUT, SLOT, FRAME_DONE, ERR
  );

  modport slave (
    input  IN, VALID, SYNC, MODE, S,
    output OUT, SLOT, FRAME_DONE, ERR
  );
endinterface

// File: rtl/tdm_demux10.sv
// Ten-line demultiplexer for a serial TDM stream: addressed writes via S, or
// framed scan distribution with SYNC, slot tracking and a frame-complete strobe.
module tdm_demux10 #(
  parameter logic [9:0] OUT_RESET = 10'b0000000000
) (
  input logic         CLK,
  input logic         RST,
  tdm_demux10_if.slave bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic [8:0] shadow_q, shadow_d;
  logic [9:0] out_q, out_d;
  logic       frameDone_q, frameDone_d;
  logic       err_q, err_d;

  // State register; reset overrides every other input in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      slot_q      <= 4'd0;
      shadow_q    <= 9'd0;
      out_q       <= OUT_RESET;
      frameDone_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      frameDone_q <= frameDone_d;
      err_q       <= err_d;
    end
  end

  // Partial scan frames live only in the shadow; OUT moves on the slot-9 bit.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    frameDone_d = 1'b0;
    err_d       = 1'b0;

    if (!bus.MODE) begin
      state_d = IDLE;
      slot_d  = 4'd0;
      if (bus.VALID) begin
        if (bus.S <= 4'd9) begin
          out_d[bus.S] = bus.IN;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (bus.VALID) begin
      unique case (state_q)
        IDLE: begin
          if (bus.SYNC) begin
            shadow_d[0] = bus.IN;
            slot_d      = 4'd1;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (bus.SYNC) begin
            // A sync anywhere but slot 0 restarts the frame and flags it.
            err_d       = (slot_q != 4'd0);
            shadow_d[0] = bus.IN;
            slot_d      = 4'd1;
          end else if (slot_q == 4'd0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (slot_q == 4'd9) begin
            out_d       = {bus.IN, shadow_q};
            frameDone_d = 1'b1;
            slot_d      = 4'd0;
          end else begin
            shadow_d[slot_q] = bus.IN;
            slot_d           = slot_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.OUT        = out_q;
  assign bus.SLOT       = slot_q;
  assign bus.FRAME_DONE = frameDone_q;
  assign bus.ERR        = err_q;

endmodule

// File: tb/tb_tdm_demux10.sv
// Bench for tdm_demux10: constant vector table, targeted frame sequences and a
// random run compared against a queue-based model of the framing rules.
module tb_tdm_demux10;

  localparam logic [9:0] OUT_RST_VAL = 10'b0000000000;

  logic CLK;
  logic RST;

  tdm_demux10_if bus ();

  tdm_demux10 #(.OUT_RESET(OUT_RST_VAL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       din;
    logic       valid;
    logic       sync;
    logic       mode;
    logic [3:0] s;
    logic [9:0] expOut;
    logic [3:0] expSlot;
    logic       expDone;
    logic       expErr;
  } vec_t;

  vec_t vecs[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a frame is just the list of bits collected since SYNC.
  logic [9:0] mOut;
  bit         mQ[$];
  bit         mSynced;
  logic       mDone;
  logic       mErr;

  task automatic modelStep(input logic rst, input logic din, input logic valid,
                           input logic sync, input logic mode, input logic [3:0] s);
    mDone = 1'b0;
    mErr  = 1'b0;
    if (rst) begin
      mOut = OUT_RST_VAL;
      mQ.delete();
      mSynced = 1'b0;
    end else if (!mode) begin
      mSynced = 1'b0;
      mQ.delete();
      if (valid) begin
        if (int'(s) < 10) mOut[s] = din;
        else mErr = 1'b1;
      end
    end else if (valid) begin
      if (sync) begin
        mErr = mSynced && (mQ.size() != 0);
        mQ.delete();
        mQ.push_back(din);
        mSynced = 1'b1;
      end else if (mSynced) begin
        if (mQ.size() == 0) begin
          mErr    = 1'b1;
          mSynced = 1'b0;
        end else begin
          mQ.push_back(din);
          if (mQ.size() == 10) begin
            for (int i = 0; i < 10; i++) mOut[i] = mQ[i];
            mDone = 1'b1;
            mQ.delete();
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic din, input logic valid,
                               input logic sync, input logic mode, input logic [3:0] s);
    RST       = rst;
    bus.IN    = din;
    bus.VALID = valid;
    bus.SYNC  = sync;
    bus.MODE  = mode;
    bus.S     = s;
    @(posedge CLK);
    modelStep(rst, din, valid, sync, mode, s);
    cyc++;
    #1;
  endtask

  task automatic checkValue(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s (cycle %0d): got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [9:0] expOut,
                             input logic [3:0] expSlot, input logic expDone,
                             input logic expErr);
    checkValue({name, ".OUT"}, bus.OUT, expOut);
    checkValue({name, ".SLOT"}, {6'd0, bus.SLOT}, {6'd0, expSlot});
    checkValue({name, ".FRAME_DONE"}, {9'd0, bus.FRAME_DONE}, {9'd0, expDone});
    checkValue({name, ".ERR"}, {9'd0, bus.ERR}, {9'd0, expErr});
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mOut, 4'(mQ.size()), mDone, mErr);
  endtask

  task automatic addVec(input logic rst, input logic din, input logic valid,
                        input logic sync, input logic mode, input logic [3:0] s,
                        input logic [9:0] expOut, input logic [3:0] expSlot,
                        input logic expDone, input logic expErr);
    vec_t v;
    v.rst = rst; v.din = din; v.valid = valid; v.sync = sync; v.mode = mode; v.s = s;
    v.expOut = expOut; v.expSlot = expSlot; v.expDone = expDone; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  task automatic sendScan(input string name, input logic din, input logic sync);
    applyStimulus(1'b0, din, 1'b1, sync, 1'b1, 4'd0);
    checkModel(name);
  endtask

  logic [9:0] frameBits;
  int         doneCycles[$];
  int         errSeen;
  int         doneSeen;
  logic       rndMode;

  initial begin
    RST = 1'b1; bus.IN = 1'b0; bus.VALID = 1'b0; bus.SYNC = 1'b0; bus.MODE = 1'b0; bus.S = 4'd0;
    mOut = OUT_RST_VAL; mSynced = 1'b0; mDone = 1'b0; mErr = 1'b0;

    // Reset held with scan activity on the inputs.
    addVec(1, 1, 1, 1, 1, 4'd0, OUT_RST_VAL, 4'd0, 0, 0);
    addVec(1, 1, 1, 1, 1, 4'd0, OUT_RST_VAL, 4'd0, 0, 0);
    // Addressed writes S=0..9 with IN=S[0].
    addVec(0, 0, 1, 0, 0, 4'd0, 10'h000, 4'd0, 0, 0);
    addVec(0, 1, 1, 0, 0, 4'd1, 10'h002, 4'd0, 0, 0);
    addVec(0, 0, 1, 0, 0, 4'd2, 10'h002, 4'd0, 0, 0);
    addVec(0, 1, 1, 0, 0, 4'd3, 10'h00A, 4'd0, 0, 0);
    addVec(0, 0, 1, 0, 0, 4'd4, 10'h00A, 4'd0, 0, 0);
    addVec(0, 1, 1, 0, 0, 4'd5, 10'h02A, 4'd0, 0, 0);
    addVec(0, 0, 1, 0, 0, 4'd6, 10'h02A, 4'd0, 0, 0);
    addVec(0, 1, 1, 0, 0, 4'd7, 10'h0AA, 4'd0, 0, 0);
    addVec(0, 0, 1, 0, 0, 4'd8, 10'h0AA, 4'd0, 0, 0);
    addVec(0, 1, 1, 0, 0, 4'd9, 10'b1010101010, 4'd0, 0, 0);
    // Illegal select, then a quiet cycle.
    addVec(0, 1, 1, 0, 0, 4'd12, 10'b1010101010, 4'd0, 0, 1);
    addVec(0, 1, 0, 0, 0, 4'd12, 10'b1010101010, 4'd0, 0, 0);
    // Scan frame 1,0,1,1,0,0,1,0,1,1 with a gap between slots 3 and 4.
    addVec(0, 1, 1, 1, 1, 4'd0, 10'b1010101010, 4'd1, 0, 0);
    addVec(0, 0, 1, 0, 1, 4'd0, 10'b1010101010, 4'd2, 0, 0);
    addVec(0, 1, 1, 0, 1, 4'd0, 10'b1010101010, 4'd3, 0, 0);
    addVec(0, 1, 1, 0, 1, 4'd0, 10'b1010101010, 4'd4, 0, 0);
    addVec(0, 1, 0, 1, 1, 4'd0, 10'b1010101010, 4'd4, 0, 0);
    addVec(0, 0, 1, 0, 1, 4'd0, 10'b1010101010, 4'd5, 0, 0);
    addVec(0, 0, 1, 0, 1, 4'd0, 10'b1010101010, 4'd6, 0, 0);
    addVec(0, 1, 1, 0, 1, 4'd0, 10'b1010101010, 4'd7, 0, 0);
    addVec(0, 0, 1, 0, 1, 4'd0, 10'b1010101010, 4'd8, 0, 0);
    addVec(0, 1, 1, 0, 1, 4'd0, 10'b1010101010, 4'd9, 0, 0);
    addVec(0, 1, 1, 0, 1, 4'd0, 10'b1101001101, 4'd0, 1, 0);
    addVec(0, 0, 0, 0, 1, 4'd0, 10'b1101001101, 4'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].din, vecs[i].valid, vecs[i].sync, vecs[i].mode, vecs[i].s);
      checkOutput($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expSlot,
                  vecs[i].expDone, vecs[i].expErr);
    end

    // Back-to-back frames: FRAME_DONE exactly 10 cycles apart, no ERR.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    checkModel("b2b_rst");
    errSeen = 0;
    doneCycles.delete();
    for (int f = 0; f < 2; f++) begin
      frameBits = 10'($urandom());
      for (int i = 0; i < 10; i++) begin
        sendScan("b2b", frameBits[i], i == 0);
        if (bus.FRAME_DONE) doneCycles.push_back(cyc);
        if (bus.ERR) errSeen++;
      end
    end
    checkValue("b2b_pulses", 10'(doneCycles.size()), 10'd2);
    if (doneCycles.size() == 2)
      checkValue("b2b_period", 10'(doneCycles[1] - doneCycles[0]), 10'd10);
    checkValue("b2b_err", 10'(errSeen), 10'd0);
    checkValue("b2b_frame2", bus.OUT, frameBits);

    // Early sync at slot 5 restarts the frame; the old frame stays on OUT.
    for (int i = 0; i < 5; i++) sendScan("early_pre", 1'($urandom()), i == 0);
    sendScan("early_sync", 1'b1, 1'b1);
    checkValue("early_err", {9'd0, bus.ERR}, 10'd1);
    checkValue("early_slot", {6'd0, bus.SLOT}, 10'd1);
    checkValue("early_out", bus.OUT, frameBits);
    frameBits = 10'($urandom());
    frameBits[0] = 1'b1;
    for (int i = 1; i < 10; i++) sendScan("early_fill", frameBits[i], 1'b0);
    checkValue("early_done", {9'd0, bus.FRAME_DONE}, 10'd1);
    checkValue("early_newout", bus.OUT, frameBits);

    // Missing sync at slot 0 while running drops to idle.
    sendScan("miss_sync", 1'b1, 1'b0);
    checkValue("miss_err", {9'd0, bus.ERR}, 10'd1);
    sendScan("miss_idle", 1'b1, 1'b0);
    checkValue("miss_idle_err", {9'd0, bus.ERR}, 10'd0);
    checkValue("miss_idle_slot", {6'd0, bus.SLOT}, 10'd0);

    // Reset mid-frame at slot 6, then unsynced bits must not complete a frame.
    for (int i = 0; i < 6; i++) sendScan("midrst_pre", 1'b1, i == 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
    checkOutput("midrst", OUT_RST_VAL, 4'd0, 1'b0, 1'b0);
    doneSeen = 0;
    for (int i = 0; i < 9; i++) begin
      sendScan("midrst_drop", 1'b1, 1'b0);
      if (bus.FRAME_DONE) doneSeen++;
    end
    checkValue("midrst_nodone", 10'(doneSeen), 10'd0);
    frameBits = 10'($urandom());
    for (int i = 0; i < 10; i++) sendScan("midrst_frame", frameBits[i], i == 0);
    checkValue("midrst_done", {9'd0, bus.FRAME_DONE}, 10'd1);

    // MODE falling mid-frame discards the partial frame silently.
    for (int i = 0; i < 4; i++) sendScan("modefall_pre", 1'b0, i == 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("modefall", frameBits, 4'd0, 1'b0, 1'b0);
    sendScan("modefall_idle", 1'b1, 1'b0);

    // Random run against the model.
    rndMode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) rndMode = ~rndMode;
      applyStimulus($urandom_range(0, 199) == 0, 1'($urandom()),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                    rndMode, 4'($urandom()));
      checkModel("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
